// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Loads a LEN/data/CHK byte stream into the instruction/data
//               memory while holding the CPU in reset, then reads every
//               loaded word back and confirms the checksum before release.
// Revision    : 1.0  initial release
// ============================================================================
module program_loader #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DWIDTH-1:0] s_data,
    output logic              s_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic              data_e,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int DEPTH = 2 ** AWIDTH;
    // Width wide enough to hold both a stream byte and the value DEPTH
    localparam int LW    = (DWIDTH > AWIDTH + 1) ? DWIDTH : AWIDTH + 1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LEN   = 4'd1,
        ST_DATA  = 4'd2,
        ST_WRITE = 4'd3,
        ST_CHK   = 4'd4,
        ST_RD    = 4'd5,
        ST_CMP   = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] addr, addr_nxt;
    logic [AWIDTH-1:0] last, last_nxt;      // address of final word (len-1)
    logic [DWIDTH-1:0] sum, sum_nxt;        // checksum of streamed bytes
    logic [DWIDTH-1:0] rsum, rsum_nxt;      // checksum of read-back words
    logic              rd_phase, rd_phase_nxt;

    logic              ready_nxt, wr_nxt, rd_nxt, done_nxt, error_nxt, hold_nxt;
    logic [AWIDTH-1:0] mem_addr_nxt;
    logic [DWIDTH-1:0] wdata_nxt;
    logic              xfer;
    logic [LW-1:0]     len_ext;

    assign xfer    = s_valid & s_ready;
    assign len_ext = LW'(s_data);

    // Next-state, datapath and next-output computation
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        last_nxt     = last;
        sum_nxt      = sum;
        rsum_nxt     = rsum;
        rd_phase_nxt = rd_phase;
        wdata_nxt    = mem_wdata;

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (xfer) begin
                    if (len_ext == '0 || len_ext > LW'(DEPTH)) begin
                        state_nxt = ST_ERR;
                    end else begin
                        last_nxt  = AWIDTH'(len_ext - LW'(1));
                        addr_nxt  = '0;
                        sum_nxt   = '0;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    wdata_nxt = s_data;
                    sum_nxt   = sum + s_data;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (addr == last) begin
                    state_nxt = ST_CHK;
                end else begin
                    addr_nxt  = addr + AWIDTH'(1);
                    state_nxt = ST_DATA;
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    if (s_data != sum) begin
                        state_nxt = ST_ERR;
                    end else begin
                        addr_nxt     = '0;
                        rsum_nxt     = '0;
                        rd_phase_nxt = 1'b0;
                        state_nxt    = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // Each word is addressed for two cycles; data is taken in the second
                if (!rd_phase) begin
                    rd_phase_nxt = 1'b1;
                end else begin
                    rd_phase_nxt = 1'b0;
                    rsum_nxt     = rsum + mem_rdata;
                    if (addr == last) begin
                        state_nxt = ST_CMP;
                    end else begin
                        addr_nxt = addr + AWIDTH'(1);
                    end
                end
            end
            ST_CMP: begin
                state_nxt = (rsum == sum) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the upcoming state
        ready_nxt    = (state_nxt == ST_LEN) || (state_nxt == ST_DATA) ||
                       (state_nxt == ST_CHK);
        wr_nxt       = (state_nxt == ST_WRITE);
        rd_nxt       = (state_nxt == ST_RD);
        done_nxt     = (state_nxt == ST_DONE);
        error_nxt    = (state_nxt == ST_ERR);
        hold_nxt     = (state_nxt != ST_DONE);
        mem_addr_nxt = (wr_nxt || rd_nxt) ? addr_nxt : mem_addr;
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            last      <= '0;
            sum       <= '0;
            rsum      <= '0;
            rd_phase  <= 1'b0;
            s_ready   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            data_e    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            last      <= last_nxt;
            sum       <= sum_nxt;
            rsum      <= rsum_nxt;
            rd_phase  <= rd_phase_nxt;
            s_ready   <= ready_nxt;
            mem_wr    <= wr_nxt;
            mem_rd    <= rd_nxt;
            data_e    <= wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= wdata_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
            cpu_hold  <= hold_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader with a
//               behavioural memory on the shared address/data lines.
// Revision    : 1.0  initial release
// ============================================================================
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [4:0] mem_addr;
    logic       mem_wr;
    logic       mem_rd;
    logic       data_e;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       cpu_hold;
    logic       done;
    logic       error;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] mem [32];
    int         wr_cnt  = 0;
    int         rd_cnt  = 0;
    int         bad_cnt = 0;
    int         last_wr = -1;
    logic       corrupt  = 1'b0;
    logic       gaps     = 1'b0;

    program_loader #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_rd),
        .data_e   (data_e),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Memory model: fault injection flips the word read at address 1
    assign mem_rdata = !mem_rd ? 8'h00 :
                       (corrupt && mem_addr == 5'd1) ? ~mem[mem_addr] : mem[mem_addr];

    // Memory writes and bus-activity bookkeeping
    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_wr       <= int'(mem_addr);
        end
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if ((mem_wr && mem_rd) || (data_e != mem_wr)) bad_cnt <= bad_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and hold it until accepted
    task automatic send(input logic [7:0] b);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                s_valid = 1'b0;
                start   = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(done || error) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("end_reached", int'(done || error), 1);
    endtask

    int wr0, rd0;

    initial begin
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(s_ready), 0);
        check("rst_wr",    int'(mem_wr), 0);
        check("rst_hold",  int'(cpu_hold), 1);
        check("rst_done",  int'({done, error}), 0);
        check("rst_addr",  int'(mem_addr), 0);
        rst = 1'b1;

        // Asynchronous reset in the middle of a write cycle
        pulse_start();
        send(8'd3);
        send(8'h11);
        begin
            int n = 0;
            while (!mem_wr && n < 20) begin @(negedge clk); n++; end
        end
        check("t1_in_write", int'(mem_wr), 1);
        #2 rst = 1'b0;
        #1;
        check("t1_wr",    int'(mem_wr), 0);
        check("t1_de",    int'(data_e), 0);
        check("t1_hold",  int'(cpu_hold), 1);
        check("t1_flags", int'({done, error}), 0);
        @(negedge clk);
        rst = 1'b1;

        // Short good load
        wr0 = wr_cnt; rd0 = rd_cnt;
        pulse_start();
        send(8'd3); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
        wait_end();
        check("t2_done",  int'(done), 1);
        check("t2_error", int'(error), 0);
        check("t2_hold",  int'(cpu_hold), 0);
        check("t2_wrs",   wr_cnt - wr0, 3);
        check("t2_rds",   rd_cnt - rd0, 6);
        check("t2_last",  last_wr, 2);
        check("t2_m0",    int'(mem[0]), 'h11);
        check("t2_m1",    int'(mem[1]), 'h22);
        check("t2_m2",    int'(mem[2]), 'h33);

        // Full-depth load, checksum wraps: 7*496 mod 256 = 0x90
        wr0 = wr_cnt; rd0 = rd_cnt;
        pulse_start();
        check("t3_restart_hold", int'(cpu_hold), 1);
        check("t3_restart_done", int'(done), 0);
        send(8'd32);
        for (int i = 0; i < 32; i++) send(8'(i * 7));
        send(8'h90);
        wait_end();
        check("t3_done", int'(done), 1);
        check("t3_wrs",  wr_cnt - wr0, 32);
        check("t3_rds",  rd_cnt - rd0, 64);
        check("t3_last", last_wr, 31);
        check("t3_m31",  int'(mem[31]), 'hd9);

        // Wrong checksum
        wr0 = wr_cnt; rd0 = rd_cnt;
        pulse_start();
        send(8'd2); send(8'h01); send(8'h02); send(8'h04);
        wait_end();
        check("t4_error", int'(error), 1);
        check("t4_done",  int'(done), 0);
        check("t4_hold",  int'(cpu_hold), 1);
        check("t4_rds",   rd_cnt - rd0, 0);
        check("t4_wrs",   wr_cnt - wr0, 2);

        // Out-of-range lengths
        wr0 = wr_cnt;
        pulse_start();
        check("t5_err_clr", int'(error), 0);
        send(8'd0);
        wait_end();
        check("t5_len0_err", int'(error), 1);
        pulse_start();
        send(8'd33);
        wait_end();
        check("t5_len33_err", int'(error), 1);
        check("t5_wrs", wr_cnt - wr0, 0);

        // Read-back fault, stream gaps and stray start pulses
        wr0 = wr_cnt; rd0 = rd_cnt;
        corrupt = 1'b1;
        gaps    = 1'b1;
        pulse_start();
        send(8'd3); send(8'h05); send(8'h06); send(8'h07); send(8'h12);
        gaps = 1'b0;
        wait_end();
        check("t6_error", int'(error), 1);
        check("t6_hold",  int'(cpu_hold), 1);
        check("t6_wrs",   wr_cnt - wr0, 3);
        check("t6_rds",   rd_cnt - rd0, 6);
        corrupt = 1'b0;
        pulse_start();
        send(8'd3); send(8'h05); send(8'h06); send(8'h07); send(8'h12);
        wait_end();
        check("t6_reload_done", int'(done), 1);
        check("t6_reload_hold", int'(cpu_hold), 0);
        check("t6_m1", int'(mem[1]), 'h06);

        check("bus_rules", bad_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
